jtcontra_gfx_romarb: RTL

Arbiter sharing the single graphics SDRAM port of the 007121 graphics block between the tilemap fetcher (scr) and the object fetcher (obj). It tracks per-requester pending state, grants the port in round-robin order, holds `rom_cs`/`rom_addr` stable for the whole transaction and returns data with a per-requester `ok` flag. It sits between `jtcontra_gfx_tilemap`/`jtcontra_gfx_obj` and the game-level SDRAM mux, and drives the chip's `rom_obj_sel` (pin H2).

---
 rtl/jtcontra_gfx_romarb.sv | 97 +++++++++
 1 files changed

// File: rtl/jtcontra_gfx_romarb.sv
// jtcontra_gfx_romarb: round-robin arbiter sharing the 007121 graphics SDRAM port between tilemap and object fetchers
module jtcontra_gfx_romarb #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    gfx_en,
    input  logic          scr_cs,
    input  logic [AW-1:0] scr_addr,
    output logic          scr_ok,
    output logic [DW-1:0] scr_data,
    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic          obj_ok,
    output logic [DW-1:0] obj_data,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    output logic          rom_obj_sel,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok
);
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
    state_t        st;
    logic          last;
    logic [AW-1:0] scr_aq, obj_aq;
    logic          scr_pend, obj_pend, scr_req, obj_req, gnt_obj, abort;
    always_comb begin
        scr_pend = scr_cs && !scr_ok;
        obj_pend = obj_cs && !obj_ok;
        scr_req  = scr_pend && gfx_en[0];
        obj_req  = obj_pend && gfx_en[1];
        gnt_obj  = obj_req && (!scr_req || !last);
        // rom_obj_sel doubles as the owner of the running transaction
        abort    = rom_obj_sel ? (!obj_cs || obj_addr != obj_aq) : (!scr_cs || scr_addr != scr_aq);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            last        <= 1'b1;
            rom_cs      <= 1'b0;
            rom_addr    <= '0;
            rom_obj_sel <= 1'b0;
            scr_ok      <= 1'b0;
            obj_ok      <= 1'b0;
            scr_data    <= '0;
            obj_data    <= '0;
            scr_aq      <= '0;
            obj_aq      <= '0;
        end else begin
            if (!scr_cs || scr_addr != scr_aq) scr_ok <= 1'b0;
            if (!obj_cs || obj_addr != obj_aq) obj_ok <= 1'b0;
            // disabled layers are answered with blank data, never touching SDRAM
            if (scr_pend && !gfx_en[0]) begin
                scr_data <= '0;
                scr_ok   <= 1'b1;
                scr_aq   <= scr_addr;
            end
            if (obj_pend && !gfx_en[1]) begin
                obj_data <= '0;
                obj_ok   <= 1'b1;
                obj_aq   <= obj_addr;
            end
            case (st)
                IDLE: if (scr_req || obj_req) begin
                    rom_cs      <= 1'b1;
                    rom_addr    <= gnt_obj ? obj_addr : scr_addr;
                    rom_obj_sel <= gnt_obj;
                    if (gnt_obj) obj_aq <= obj_addr;
                    else scr_aq <= scr_addr;
                    st          <= WAIT;
                end
                WAIT: begin
                    // rom_ok here may still belong to the previous transaction
                    rom_cs <= !abort;
                    st     <= abort ? IDLE : DATA;
                end
                DATA: if (abort) begin
                    rom_cs <= 1'b0;
                    st     <= IDLE;
                end else if (rom_ok) begin
                    if (rom_obj_sel) begin
                        obj_data <= rom_data;
                        obj_ok   <= 1'b1;
                    end else begin
                        scr_data <= rom_data;
                        scr_ok   <= 1'b1;
                    end
                    rom_cs <= 1'b0;
                    last   <= rom_obj_sel;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
